// File: rtl/wb_riot_timer.sv
// 6532 RIOT slave for the console bus: two 8-bit I/O ports with direction registers
// and the INTIM/TIMINT interval timer, which counts 6502 cycles signalled by ready_i.

module wb_riot_port #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_out,
  input  logic         wr_ddr,
  input  logic [W-1:0] wdata,
  input  logic [W-1:0] pins,
  output logic [W-1:0] latch,
  output logic [W-1:0] ddr,
  output logic [W-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch <= '0;
      ddr   <= '0;
    end else begin
      if (wr_out) latch <= wdata;
      if (wr_ddr) ddr   <= wdata;
    end
  end

  // Output bits read back the latch, input bits read the pins.
  assign rdata = (ddr & latch) | (~ddr & pins);
endmodule

module wb_riot_timer #(
  parameter int WB_ADDR_WIDTH = 7,
  parameter int WB_DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ready_i,
  input  logic [7:0]               pa_i,
  input  logic [7:0]               pb_i,
  output logic [7:0]               pa_o,
  output logic [7:0]               pb_o,
  output logic [7:0]               pa_oe_o,
  output logic [7:0]               pb_oe_o,
  output logic                     irq_o
);
  localparam int NUM_PORTS = 2;
  localparam int PW        = 8;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [4:0] reg_a;
    logic [7:0] wdata;
  } bus_req_t;

  bus_req_t req;
  logic     acc;
  logic     adr_unused;

  // An access is the cycle whose edge raises ack_o.
  assign acc        = stb_i & ~ack_o;
  assign adr_unused = ^adr_i[WB_ADDR_WIDTH-1:5];

  always_comb begin
    req.rd    = acc & ~we_i;
    req.wr    = acc & we_i;
    req.reg_a = adr_i[4:0];
    req.wdata = dat_i[7:0];
  end

  logic [NUM_PORTS-1:0][PW-1:0] pins, latch, ddr, prd;

  assign pins = {pb_i, pa_i};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      wb_riot_port #(.W(PW)) u_port (
        .clk    (clk_i),
        .rst_n  (rst_i),
        .wr_out (req.wr && req.reg_a == 5'(2*p)),
        .wr_ddr (req.wr && req.reg_a == 5'(2*p+1)),
        .wdata  (req.wdata),
        .pins   (pins[p]),
        .latch  (latch[p]),
        .ddr    (ddr[p]),
        .rdata  (prd[p])
      );
    end
  endgenerate

  assign pa_o    = latch[0];
  assign pb_o    = latch[1];
  assign pa_oe_o = ddr[0];
  assign pb_oe_o = ddr[1];

  logic [7:0] timer, timer_d;
  logic [9:0] prescale, prescale_d;
  logic [9:0] reload, reload_d;   // programmed interval minus one
  logic [9:0] sel_reload;
  logic       flag, flag_d, fast, fast_d;
  logic       tim_wr, intim_rd, underflow;
  logic [7:0] rdata;

  assign tim_wr   = req.wr && req.reg_a[4:2] == 3'b101;
  assign intim_rd = req.rd && req.reg_a == 5'h04;

  always_comb begin
    case (req.reg_a[1:0])
      2'd0:    sel_reload = 10'd0;
      2'd1:    sel_reload = 10'd7;
      2'd2:    sel_reload = 10'd63;
      default: sel_reload = 10'd1023;
    endcase
  end

  // Write beats tick; underflow beats the INTIM read's flag clear.
  always_comb begin
    timer_d    = timer;
    prescale_d = prescale;
    reload_d   = reload;
    flag_d     = flag;
    fast_d     = fast;
    underflow  = 1'b0;
    if (tim_wr) begin
      timer_d    = req.wdata;
      reload_d   = sel_reload;
      prescale_d = sel_reload;
      flag_d     = 1'b0;
      fast_d     = 1'b0;
    end else begin
      if (ready_i) begin
        if (prescale != '0 && !fast) begin
          prescale_d = prescale - 10'd1;
        end else begin
          timer_d    = timer - 8'd1;
          prescale_d = reload;
          underflow  = (timer == 8'h00);
        end
      end
      if (intim_rd) begin
        flag_d     = 1'b0;
        fast_d     = 1'b0;
        prescale_d = reload;
      end
      if (underflow) begin
        flag_d = 1'b1;
        fast_d = 1'b1;
      end
    end
  end

  always_comb begin
    case (req.reg_a)
      5'h00:   rdata = prd[0];
      5'h01:   rdata = ddr[0];
      5'h02:   rdata = prd[1];
      5'h03:   rdata = ddr[1];
      5'h04:   rdata = timer;
      5'h05:   rdata = {flag, 7'b0};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      timer    <= 8'h00;
      prescale <= 10'd1023;
      reload   <= 10'd1023;
      flag     <= 1'b0;
      fast     <= 1'b0;
    end else begin
      ack_o    <= stb_i & ~ack_o;
      if (req.rd) dat_o <= rdata;
      timer    <= timer_d;
      prescale <= prescale_d;
      reload   <= reload_d;
      flag     <= flag_d;
      fast     <= fast_d;
    end
  end

  assign irq_o = flag;
endmodule

// File: tb/tb_wb_riot_timer.sv
// Scoreboard bench for wb_riot_timer: directed timer/port scenarios plus random traffic,
// checked against a tick-count model of the RIOT timer.
`timescale 1ns/1ps
module tb_wb_riot_timer;
  logic       clk_i = 1'b0, rst_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, ready_i = 1'b0;
  logic [6:0] adr_i = '0;
  logic [7:0] dat_i = '0, pa_i = 8'hFF, pb_i = 8'hFF;
  logic       ack_o, irq_o;
  logic [7:0] dat_o, pa_o, pb_o, pa_oe_o, pb_oe_o;

  always #5 clk_i = ~clk_i;

  wb_riot_timer #(.WB_ADDR_WIDTH(7), .WB_DATA_WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
    .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .ready_i(ready_i),
    .pa_i(pa_i), .pb_i(pb_i), .pa_o(pa_o), .pb_o(pb_o),
    .pa_oe_o(pa_oe_o), .pb_oe_o(pb_oe_o), .irq_o(irq_o)
  );

  typedef struct {
    string      nm;
    logic [7:0] dat;
    logic       irq;
    logic [7:0] pa, pae, pb, pbe;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0;

  // Model: timer value is derived from ticks counted since the last load/rebase.
  int         m_base, m_ivl, m_k;
  bit         m_flag, m_ack;
  logic [7:0] m_last, m_pa, m_pae, m_pb, m_pbe;
  logic [7:0] pa_nx = 8'hFF, pb_nx = 8'hFF;
  int         ivl_tab[4] = '{1, 8, 64, 1024};

  function automatic logic [7:0] m_timer();
    int lim = (m_base + 1) * m_ivl;
    if (m_k < lim) return 8'(m_base - m_k / m_ivl);
    return 8'(-1 - (m_k - lim));
  endfunction

  function automatic void m_reset();
    m_base = 0; m_ivl = 1024; m_k = 0; m_flag = 0; m_ack = 0;
    m_last = 8'h00; m_pa = 8'h00; m_pae = 8'h00; m_pb = 8'h00; m_pbe = 8'h00;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, got, want);
    end
  endtask

  task automatic m_edge(input logic stb, input logic we, input logic [6:0] adr,
                        input logic [7:0] dat, input logic rdy, input int fexp, input string nm);
    logic       acc;
    logic [4:0] a;
    logic [7:0] rv;
    bit         uf;
    int         lim;
    exp_t       e;
    acc = stb & ~m_ack;
    m_ack = acc;
    a = adr[4:0];
    uf = 0;
    rv = m_last;
    if (acc && !we) begin
      case (a)
        5'd0:    rv = (m_pae & m_pa) | (~m_pae & pa_i);
        5'd1:    rv = m_pae;
        5'd2:    rv = (m_pbe & m_pb) | (~m_pbe & pb_i);
        5'd3:    rv = m_pbe;
        5'd4:    rv = m_timer();
        5'd5:    rv = {m_flag, 7'b0};
        default: rv = 8'h00;
      endcase
      m_last = rv;
    end
    if (acc && we && a[4:2] == 3'b101) begin
      m_base = int'(dat); m_ivl = ivl_tab[a[1:0]]; m_k = 0; m_flag = 0;
    end else begin
      if (rdy) begin
        m_k++;
        lim = (m_base + 1) * m_ivl;
        uf = (m_k >= lim) && ((m_k - lim) % 256 == 0);
        if (uf) m_flag = 1;
      end
      if (acc && !we && a == 5'd4 && !uf) begin
        m_base = int'(m_timer()); m_k = 0; m_flag = 0;
      end
    end
    if (acc && we) begin
      case (a)
        5'd0: m_pa  = dat;
        5'd1: m_pae = dat;
        5'd2: m_pb  = dat;
        5'd3: m_pbe = dat;
        default: ;
      endcase
    end
    if (acc) begin
      e.nm = nm;
      e.dat = (fexp >= 0) ? 8'(fexp) : m_last;
      e.irq = m_flag;
      e.pa = m_pa; e.pae = m_pae; e.pb = m_pb; e.pbe = m_pbe;
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input logic stb, input logic we, input logic [6:0] adr, input logic [7:0] dat,
                     input logic rdy, input int fexp = -1, input string nm = "acc");
    @(posedge clk_i); #1;
    stb_i = stb; we_i = we; adr_i = adr; dat_i = dat; ready_i = rdy;
    pa_i = pa_nx; pb_i = pb_nx;
    m_edge(stb, we, adr, dat, rdy, fexp, nm);
  endtask

  task automatic rd(input logic [6:0] adr, input int fexp, input string nm);
    cyc(1'b1, 1'b0, adr, 8'h00, 1'b0, fexp, nm);
    cyc(1'b0, 1'b0, adr, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [6:0] adr, input logic [7:0] dat);
    cyc(1'b1, 1'b1, adr, dat, 1'b0, -1, "wr");
    cyc(1'b0, 1'b0, adr, 8'h00, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ack"}, {7'b0, ack_o}, 8'h00);
    check({tag, "_dat"}, dat_o, 8'h00);
    check({tag, "_irq"}, {7'b0, irq_o}, 8'h00);
    check({tag, "_pa"}, pa_o, 8'h00);
    check({tag, "_paoe"}, pa_oe_o, 8'h00);
    check({tag, "_pb"}, pb_o, 8'h00);
    check({tag, "_pboe"}, pb_oe_o, 8'h00);
  endtask

  // Monitor: every acknowledge pops one scoreboard entry.
  initial forever begin
    @(negedge clk_i);
    if (rst_i && ack_o) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_ack: got ack with nothing pending, want no ack");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.nm, "_dat"}, dat_o, mon_e.dat);
        check({mon_e.nm, "_irq"}, {7'b0, irq_o}, {7'b0, mon_e.irq});
        check({mon_e.nm, "_pa"}, pa_o, mon_e.pa);
        check({mon_e.nm, "_paoe"}, pa_oe_o, mon_e.pae);
        check({mon_e.nm, "_pb"}, pb_o, mon_e.pb);
        check({mon_e.nm, "_pboe"}, pb_oe_o, mon_e.pbe);
      end
    end
  end

  initial begin
    logic [6:0] ra;
    int         op;
    m_reset();
    #12;
    check_reset_outs("por");
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    rd(7'h05, 8'h00, "timint_rst");
    rd(7'h04, 8'h00, "intim_rst");

    // TIM64T countdown through underflow and fast mode
    wr(7'h16, 8'h03);
    ticks(64);  rd(7'h04, 8'h02, "intim_64");
    ticks(128); rd(7'h04, 8'h00, "intim_192");
    ticks(64);  rd(7'h05, 8'h80, "timint_uf");
    ticks(5);   rd(7'h04, 8'hFA, "intim_fast");
    rd(7'h05, 8'h00, "timint_clr");
    ticks(63);  rd(7'h04, 8'hFA, "intim_hold");
    ticks(64);  rd(7'h04, 8'hF9, "intim_next");

    // Ports
    wr(7'h01, 8'hF0); wr(7'h00, 8'hA5);
    pa_nx = 8'h3C; rd(7'h00, 8'hAC, "swcha");
    wr(7'h03, 8'h0F); wr(7'h02, 8'h5A);
    pb_nx = 8'hC3; rd(7'h02, 8'hCA, "swchb");
    rd(7'h03, 8'h0F, "swbcnt");
    rd(7'h21, 8'hF0, "swacnt_alias");

    // TIM1T write on a ready edge: write wins
    cyc(1'b1, 1'b1, 7'h14, 8'h10, 1'b1, -1, "tim1t_rdy");
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    rd(7'h04, 8'h10, "intim_t1");
    ticks(1); rd(7'h04, 8'h0F, "intim_t1_dec");

    // INTIM read on the underflow edge: underflow wins
    wr(7'h14, 8'h00);
    cyc(1'b1, 1'b0, 7'h04, 8'h00, 1'b1, 8'h00, "intim_uf_edge");
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    rd(7'h05, 8'h80, "timint_after_uf_edge");

    // TIMINT read on the underflow edge returns the old flag
    wr(7'h14, 8'h01); ticks(1);
    cyc(1'b1, 1'b0, 7'h05, 8'h00, 1'b1, 8'h00, "timint_old");
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    rd(7'h65, 8'h80, "timint_new");

    // Held strobe acks every other clock; unmapped and read-only writes
    repeat (4) cyc(1'b1, 1'b0, 7'h05, 8'h00, 1'b0, -1, "held");
    cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    rd(7'h0A, 8'h00, "unmapped");
    wr(7'h05, 8'h55); wr(7'h0B, 8'h77);
    rd(7'h15, 8'h00, "tim_wo_read");

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      op = $urandom_range(0, 9);
      pa_nx = 8'($urandom); pb_nx = 8'($urandom);
      if (op < 4) begin
        ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
        cyc(1'b1, 1'b0, ra, 8'h00, 1'($urandom_range(0, 2) == 0), -1, "rnd_rd");
        cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'($urandom_range(0, 2) == 0));
      end else if (op < 6) begin
        ra = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'($urandom_range(0, 3));
        cyc(1'b1, 1'b1, ra, 8'($urandom), 1'($urandom_range(0, 2) == 0), -1, "rnd_wr");
        cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'($urandom_range(0, 2) == 0));
      end else if (op == 6) begin
        ra = {2'($urandom), 3'b101, 2'($urandom_range(0, 2))};
        cyc(1'b1, 1'b1, ra, 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), -1, "rnd_tim");
        cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(1, 20)) cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset mid-countdown with the flag set and ack high
    wr(7'h01, 8'h81); wr(7'h02, 8'h42);
    wr(7'h14, 8'h01); ticks(3);
    cyc(1'b1, 1'b0, 7'h05, 8'h00, 1'b0, 8'h80, "timint_pre_rst");
    @(posedge clk_i); #2;
    check("pre_rst_ack", {7'b0, ack_o}, 8'h01);
    check("pre_rst_dat", dat_o, 8'h80);
    check("pre_rst_irq", {7'b0, irq_o}, 8'h01);
    #1;
    rst_i = 1'b0; stb_i = 1'b0; ready_i = 1'b0;
    #1;
    check_reset_outs("async_rst");
    sb.delete();
    m_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    rd(7'h04, 8'h00, "intim_post_rst");
    rd(7'h05, 8'h00, "timint_post_rst");
    repeat (3) cyc(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_ack: got %0d accesses unacknowledged, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
